// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU/load units, decode stage and the register-file write arbiter.
// The master side drives requests and decode queries; the slave side (the arbiter) answers.
interface regfile_write_arbiter_if;
  logic        alu_wr_req;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic        alu_busy;

  logic        mem_wr_req;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_busy;

  logic [4:0]  wr_port_C;
  logic [31:0] wr_data_C;
  logic        write_en_c;
  logic        write_back;
  logic [15:0] wr_count;

  logic [4:0]  rd_port_A;
  logic [4:0]  rd_port_B;
  logic        rd_stall_a;
  logic        rd_stall_b;

  modport master (
    output alu_wr_req, alu_wr_addr, alu_wr_data,
    output mem_wr_req, mem_wr_addr, mem_wr_data,
    output rd_port_A, rd_port_B,
    input  alu_busy, mem_busy,
    input  wr_port_C, wr_data_C, write_en_c, write_back, wr_count,
    input  rd_stall_a, rd_stall_b
  );

  modport slave (
    input  alu_wr_req, alu_wr_addr, alu_wr_data,
    input  mem_wr_req, mem_wr_addr, mem_wr_data,
    input  rd_port_A, rd_port_B,
    output alu_busy, mem_busy,
    output wr_port_C, wr_data_C, write_en_c, write_back, wr_count,
    output rd_stall_a, rd_stall_b
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-source (ALU / load) register-file write arbiter with one holding slot per source.
// Define RF_HAZARD_CHECK_EN to enable the decode-stage read-after-write stall outputs.
module regfile_write_arbiter (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              alu_vld_q, alu_vld_d;
  logic [ADDR_W-1:0] alu_addr_q, alu_addr_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic              mem_vld_q, mem_vld_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              age_q, age_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_port_q, wr_port_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic alu_keep, mem_keep;
  logic issue_alu, issue_mem;

  always_comb begin
    // Writes to r0 are accepted on the handshake but never occupy a slot.
    alu_keep  = bus.alu_wr_req && !alu_vld_q && (bus.alu_wr_addr != '0);
    mem_keep  = bus.mem_wr_req && !mem_vld_q && (bus.mem_wr_addr != '0);

    // age_q = 1 means the load slot holds the older entry.
    issue_alu = alu_vld_q && (!mem_vld_q || !age_q);
    issue_mem = mem_vld_q && !issue_alu;

    alu_vld_d  = alu_keep ? 1'b1 : (issue_alu ? 1'b0 : alu_vld_q);
    alu_addr_d = alu_keep ? bus.alu_wr_addr : alu_addr_q;
    alu_data_d = alu_keep ? bus.alu_wr_data : alu_data_q;
    mem_vld_d  = mem_keep ? 1'b1 : (issue_mem ? 1'b0 : mem_vld_q);
    mem_addr_d = mem_keep ? bus.mem_wr_addr : mem_addr_q;
    mem_data_d = mem_keep ? bus.mem_wr_data : mem_data_q;

    age_d = 1'b0;
    if (alu_vld_d && mem_vld_d) begin
      if (alu_keep && mem_keep)
        age_d = 1'b0;
      else if (mem_keep)
        age_d = 1'b0;
      else if (alu_keep)
        age_d = 1'b1;
      else
        age_d = age_q;
    end

    wr_en_d    = issue_alu || issue_mem;
    wr_port_d  = wr_port_q;
    wr_data_d  = wr_data_q;
    if (issue_alu) begin
      wr_port_d = alu_addr_q;
      wr_data_d = alu_data_q;
    end else if (issue_mem) begin
      wr_port_d = mem_addr_q;
      wr_data_d = mem_data_q;
    end
    wr_count_d = wr_count_q + CNT_W'(wr_en_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_vld_q  <= 1'b0;
      mem_vld_q  <= 1'b0;
      age_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_port_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
    end else begin
      alu_vld_q  <= alu_vld_d;
      mem_vld_q  <= mem_vld_d;
      age_q      <= age_d;
      wr_en_q    <= wr_en_d;
      wr_port_q  <= wr_port_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Slot payloads are only meaningful while the matching valid is set.
  always_ff @(posedge clk) begin
    alu_addr_q <= alu_addr_d;
    alu_data_q <= alu_data_d;
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  assign bus.alu_busy   = alu_vld_q;
  assign bus.mem_busy   = mem_vld_q;
  assign bus.wr_port_C  = wr_port_q;
  assign bus.wr_data_C  = wr_data_q;
  assign bus.write_en_c = wr_en_q;
  assign bus.write_back = wr_en_q;
  assign bus.wr_count   = wr_count_q;

`ifdef RF_HAZARD_CHECK_EN
  assign bus.rd_stall_a = (bus.rd_port_A != '0) &&
                          ((alu_vld_q && (bus.rd_port_A == alu_addr_q)) ||
                           (mem_vld_q && (bus.rd_port_A == mem_addr_q)) ||
                           (wr_en_q   && (bus.rd_port_A == wr_port_q)));
  assign bus.rd_stall_b = (bus.rd_port_B != '0) &&
                          ((alu_vld_q && (bus.rd_port_B == alu_addr_q)) ||
                           (mem_vld_q && (bus.rd_port_B == mem_addr_q)) ||
                           (wr_en_q   && (bus.rd_port_B == wr_port_q)));
`else
  logic unused_rd_ports;
  assign unused_rd_ports = ^{bus.rd_port_A, bus.rd_port_B};
  assign bus.rd_stall_a  = 1'b0;
  assign bus.rd_stall_b  = 1'b0;
`endif
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (5-bit register address, 32-bit data).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 alu_wr_req  input  1  ALU writeback request; qualified by alu_busy low.
REQ-005 alu_wr_addr  input  5  ALU destination register.
REQ-006 alu_wr_data  input  32  ALU result.
REQ-007 alu_busy  output  1  ALU holding slot occupied; ALU requests ignored while high.
REQ-008 mem_wr_req  input  1  load-unit writeback request; qualified by mem_busy low.
REQ-009 mem_wr_addr  input  5  load destination register.
REQ-010 mem_wr_data  input  32  load data.
REQ-011 mem_busy  output  1  load holding slot occupied.
REQ-012 wr_port_C  output  5  register-file write address, registered.
REQ-013 wr_data_C  output  32  register-file write data, registered, passed unmodified.
REQ-014 write_en_c  output  1  register-file write enable, one-cycle pulse per issued write.
REQ-015 write_back  output  1  write-back stage strobe; equals write_en_c.
REQ-016 rd_port_A, rd_port_B  input  5 each  decode-stage source registers under query.
REQ-017 rd_stall_a, rd_stall_b  output  1 each  source register has a write pending.
REQ-018 wr_count  output  16  number of writes issued, wraps modulo 2^16.

Function
REQ-019 Each requester SHALL own one holding slot (valid, addr, data); busy output = slot valid.
REQ-020 A request SHALL be captured on a rising edge when req=1 and busy=0; busy rises the next cycle.
REQ-021 A request to address 0 SHALL be accepted but discarded: slot stays empty, no write issued, wr_count unchanged.
REQ-022 Each cycle with at least one valid slot, the arbiter SHALL issue exactly one slot: the only valid slot, or the older slot when both are valid.
REQ-023 Age: a 1-bit flag SHALL record which slot was captured first; on simultaneous capture, ALU is older.
REQ-024 Issue SHALL register wr_port_C/wr_data_C from the slot, pulse write_en_c=write_back=1 for one cycle, clear the slot, and increment wr_count.
REQ-025 Latency: request captured at edge N -> write_en_c high during cycle N+1..N+2 when uncontested; +1 cycle when losing arbitration.
REQ-026 A slot cleared by issue at edge N SHALL accept a new request no earlier than edge N+1 (busy is registered).
REQ-027 With no valid slot, write_en_c=write_back=0 and wr_port_C/wr_data_C SHALL hold their last values.
REQ-028 Same-address writes in both slots SHALL issue in age order, so the younger value is final.
REQ-029 rd_stall_a SHALL be combinational: 1 when rd_port_A is nonzero and equals the addr of any valid slot or of wr_port_C while write_en_c=1; same for rd_stall_b/rd_port_B.
REQ-030 Register 0 SHALL never cause a stall.

Reset
REQ-031 Reset SHALL clear both slot valids, age flag, write_en_c, write_back, wr_port_C, wr_data_C, wr_count to 0.
REQ-032 Reset mid-operation SHALL discard pending slots; no write issues in the cycle reset deasserts.
REQ-033 Requests presented while reset is high SHALL be ignored.

Configuration
REQ-034 Macro RF_HAZARD_CHECK_EN defined: rd_stall_a/rd_stall_b behave per REQ-029/REQ-030.
REQ-035 Macro RF_HAZARD_CHECK_EN undefined: rd_stall_a/rd_stall_b tied to 0 and comparison logic omitted; all other behaviour unchanged.

Verification
REQ-036 ALU only: alu_wr_req, addr 5, data 0x1234_5678 -> next cycle alu_busy=1; one cycle later write_en_c=1, wr_port_C=5, wr_data_C=0x1234_5678, wr_count=1.
REQ-037 Simultaneous ALU addr 3 data 0xA and load addr 3 data 0xB -> two consecutive write pulses, 0xA then 0xB, wr_count=2.
REQ-038 Load captured one cycle before ALU -> load write issues first, ALU write next cycle.
REQ-039 Request to addr 0 data 0xFFFF_FFFF -> busy stays 0, no write_en_c pulse, wr_count unchanged.
REQ-040 Slot pending addr 7 with rd_port_A=7 -> rd_stall_a=1 (0 with macro undefined); drops to 0 the cycle after the write pulse ends.
REQ-041 Assert reset with both slots valid -> busy outputs, write_en_c, wr_count read 0 immediately; no write after deassertion.
